// File: rtl/mul_seq_controller_pkg.sv
// Shared state encoding and sizing helpers for the sequential shift-add multiplier.
package mul_seq_controller_pkg;

  localparam int MUL_STATE_LEN = 2;
  localparam int WORD_LEN_DEF  = 32;

  typedef enum logic [MUL_STATE_LEN-1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // Counter width that stays legal even when the whole product takes one step.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/mul_step_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand/multiplier and the
// STEP_BITS-wide partial-product adder, driven by load/step from the sequencer.
module mul_step_dp
  import mul_seq_controller_pkg::*;
#(
  parameter int WORD_LEN  = WORD_LEN_DEF,
  parameter int STEP_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [WORD_LEN-1:0] op_a,
  input  logic [WORD_LEN-1:0] op_b,
  output logic [WORD_LEN-1:0] acc_nxt
);

  logic [WORD_LEN-1:0] acc;
  logic [WORD_LEN-1:0] mcand;
  logic [WORD_LEN-1:0] mplier;
  logic [WORD_LEN-1:0] pp_sum;

  // Low-order product bits do not depend on signedness, so plain modular adds suffice.
  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (mplier[i]) pp_sum = pp_sum + (mcand << i);
    end
    acc_nxt = acc + pp_sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= mcand << STEP_BITS;
      mplier <= mplier >> STEP_BITS;
    end
  end

endmodule

// File: rtl/mul_seq_controller.sv
// Sequencer for the multi-cycle EXE multiplier: freezes IF/ID/EXE while the
// product is built, then releases the pipeline for one cycle with done/result.
module mul_seq_controller
  import mul_seq_controller_pkg::*;
#(
  parameter int WORD_LEN  = WORD_LEN_DEF,
  parameter int STEP_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                flush,
  input  logic [WORD_LEN-1:0] op_a,
  input  logic [WORD_LEN-1:0] op_b,
  output logic                freeze,
  output logic                done,
  output logic [WORD_LEN-1:0] result
);

  localparam int               STEPS    = WORD_LEN / STEP_BITS;
  localparam int               CNT_W    = cnt_width(STEPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  mul_state_t          state;
  mul_state_t          state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                load;
  logic                step;
  logic                finish;
  logic [WORD_LEN-1:0] acc_nxt;

  mul_step_dp #(
    .WORD_LEN  (WORD_LEN),
    .STEP_BITS (STEP_BITS)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .op_a    (op_a),
    .op_b    (op_b),
    .acc_nxt (acc_nxt)
  );

  // start is ignored in DONE: the same MUL is still sitting in EXE that cycle.
  always_comb begin
    state_nxt = state;
    freeze    = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      MUL_IDLE: begin
        if (start && !flush) begin
          freeze    = 1'b1;
          load      = 1'b1;
          state_nxt = MUL_RUN;
        end
      end
      MUL_RUN: begin
        freeze = 1'b1;
        if (flush) begin
          state_nxt = MUL_IDLE;
        end else begin
          step = 1'b1;
          if (cnt == LAST_CNT) begin
            finish    = 1'b1;
            state_nxt = MUL_DONE;
          end
        end
      end
      MUL_DONE: state_nxt = MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
    if (!rst) freeze = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nxt;
      done  <= finish;
      if (finish) result <= acc_nxt;
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mul_seq_controller.sv
// Self-checking bench for mul_seq_controller (WORD_LEN=32, STEP_BITS=2).
module tb_mul_seq_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        freeze;
  logic        done;
  logic [31:0] result;

  int          checks;
  int          errors;
  logic [31:0] last_result;

  mul_seq_controller dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .op_a   (op_a),
    .op_b   (op_b),
    .freeze (freeze),
    .done   (done),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Full product truncated to 32 bits: the only arithmetic the reference needs.
  function automatic logic [31:0] ref_product(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = {32'd0, a} * {32'd0, b};
    return full[31:0];
  endfunction

  // One MUL held in EXE from its start cycle through its done cycle (cycles 0..17).
  task automatic mul_op(input logic [31:0] a, input logic [31:0] b, input string nm);
    logic [31:0] exp;
    logic [31:0] want_res;
    exp = ref_product(a, b);
    for (int k = 0; k <= 17; k++) begin
      @(posedge clk); #1;
      start = 1'b1;
      flush = 1'b0;
      if (k == 0) begin
        op_a = a;
        op_b = b;
      end else begin
        op_a = $urandom;
        op_b = $urandom;
      end
      @(negedge clk);
      checks++;
      if (freeze !== 1'(k <= 16)) begin
        errors++;
        $display("FAIL %s freeze cycle %0d: got %b want %b", nm, k, freeze, (k <= 16));
      end
      checks++;
      if (done !== 1'(k == 17)) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b want %b", nm, k, done, (k == 17));
      end
      want_res = (k == 17) ? exp : last_result;
      checks++;
      if (result !== want_res) begin
        errors++;
        $display("FAIL %s result cycle %0d: got %h want %h", nm, k, result, want_res);
      end
    end
    last_result = exp;
  endtask

  task automatic idle_cycles(input int n, input string nm);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
      op_a  = $urandom;
      op_b  = $urandom;
      @(negedge clk);
      checks++;
      if (freeze !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s idle %0d: got freeze=%b done=%b want 0/0", nm, k, freeze, done);
      end
      checks++;
      if (result !== last_result) begin
        errors++;
        $display("FAIL %s idle %0d result: got %h want %h", nm, k, result, last_result);
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b1;
    flush = 1'b0;
    op_a  = 32'd7;
    op_b  = 32'd6;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (freeze !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
        errors++;
        $display("FAIL reset: got freeze=%b done=%b result=%h want 0/0/0", freeze, done, result);
      end
    end
    rst         = 1'b1;
    start       = 1'b0;
    last_result = 32'd0;
    idle_cycles(2, "post_reset");
  endtask

  task automatic test_basic();
    mul_op(32'd7, 32'd6, "basic_7x6");
    idle_cycles(4, "basic_after_done");
  endtask

  task automatic test_wrap();
    mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "wrap_ffxff");
    idle_cycles(1, "wrap_gap");
    mul_op(32'h8000_0000, 32'd2, "wrap_8000x2");
    idle_cycles(1, "wrap_tail");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int n = 0; n < 10; n++) begin
      a = $urandom;
      b = $urandom;
      if (n % 3 == 1) b = b >> $urandom_range(31, 0);
      mul_op(a, b, "random");
      idle_cycles($urandom_range(2, 0), "random_gap");
    end
  endtask

  task automatic test_back_to_back();
    mul_op(32'd3, 32'd5, "b2b_first");
    mul_op(32'd9, 32'd9, "b2b_second");
    idle_cycles(3, "b2b_after");
  endtask

  task automatic test_flush_run();
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk); #1;
      start = (k < 5);
      flush = (k == 5);
      op_a  = (k == 0) ? 32'd11 : $urandom;
      op_b  = (k == 0) ? 32'd13 : $urandom;
      @(negedge clk);
      if (k < 5) begin
        checks++;
        if (freeze !== 1'b1) begin
          errors++;
          $display("FAIL flush_run freeze cycle %0d: got %b want 1", k, freeze);
        end
      end
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL flush_run done cycle %0d: got %b want 0", k, done);
      end
    end
    idle_cycles(20, "flush_run_after");
  endtask

  task automatic test_flush_idle();
    @(posedge clk); #1;
    start = 1'b1;
    flush = 1'b1;
    op_a  = 32'd5;
    op_b  = 32'd5;
    @(negedge clk);
    checks++;
    if (freeze !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got freeze=%b done=%b want 0/0", freeze, done);
    end
    idle_cycles(20, "flush_idle_after");
  endtask

  task automatic test_async_reset();
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      start = 1'b1;
      flush = 1'b0;
      op_a  = (k == 0) ? 32'h0000_1234 : $urandom;
      op_b  = (k == 0) ? 32'h0000_0055 : $urandom;
      @(negedge clk);
      checks++;
      if (freeze !== 1'b1) begin
        errors++;
        $display("FAIL async_reset pre freeze cycle %0d: got %b want 1", k, freeze);
      end
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (freeze !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL async_reset immediate: got freeze=%b done=%b result=%h want 0/0/0",
               freeze, done, result);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (freeze !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL async_reset held: got freeze=%b done=%b result=%h want 0/0/0",
               freeze, done, result);
    end
    rst         = 1'b1;
    start       = 1'b0;
    last_result = 32'd0;
    idle_cycles(2, "async_reset_release");
    mul_op(32'd4, 32'd4, "async_reset_4x4");
    idle_cycles(2, "async_reset_tail");
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    last_result = 32'd0;
    rst         = 1'b0;
    start       = 1'b0;
    flush       = 1'b0;
    op_a        = 32'd0;
    op_b        = 32'd0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_flush_run();
    test_flush_idle();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
